// File: rtl/frontend_cmd_definition_pkg.sv
// Shared Global Controller frontend definitions.
// Holds the default backend-channel count, read word width, order-FIFO depth
// and head-wait timeout used by the read-return path, plus the channel id type.
package frontend_cmd_definition_pkg;

    localparam int GC_NUM_BC      = 4;
    localparam int GC_DATA_W      = 128;
    localparam int GC_ORDER_DEPTH = 16;
    localparam int GC_TIMEOUT     = 1023;

    typedef logic [$clog2(GC_NUM_BC)-1:0] bc_id_t;

endpackage

// File: rtl/gc_order_fifo.sv
// Synchronous first-word-fall-through FIFO recording the issue order of reads.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   push_i, din_i   write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   dout_o          head entry, valid whenever empty_o is low
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module gc_order_fifo
    import frontend_cmd_definition_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = GC_ORDER_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/gc_read_return_sequencer.sv
// In-order read-return path of the Global Controller.
// Records the backend channel of every issued read and pops returned data from
// the NUM_CH backend FIFOs strictly in that order, presenting it to the core as
// a registered valid/data pulse. A watchdog flags a head read waiting too long.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_issue_valid/i_issue_ch  read issued by the dispatcher and its channel
//   o_issue_ready             order FIFO has room
//   i_ret_valid/i_ret_data    per-channel FWFT return data
//   o_ret_ren                 per-channel pop strobe (one-hot or zero)
//   o_read_data_valid/_data   registered return to the core
//   o_outstanding             reads issued and not yet returned
//   o_timeout                 sticky: head waited TIMEOUT cycles
//   o_bad_ch                  sticky: issue to a nonexistent channel
module gc_read_return_sequencer
    import frontend_cmd_definition_pkg::*;
#(
    parameter int NUM_CH      = GC_NUM_BC,
    parameter int DATA_W      = GC_DATA_W,
    parameter int ORDER_DEPTH = GC_ORDER_DEPTH,
    parameter int TIMEOUT     = GC_TIMEOUT
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_issue_valid,
    input  logic [$clog2(NUM_CH)-1:0]        i_issue_ch,
    output logic                             o_issue_ready,
    input  logic [NUM_CH-1:0]                i_ret_valid,
    input  logic [NUM_CH*DATA_W-1:0]         i_ret_data,
    output logic [NUM_CH-1:0]                o_ret_ren,
    output logic                             o_read_data_valid,
    output logic [DATA_W-1:0]                o_read_data,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] o_outstanding,
    output logic                             o_timeout,
    output logic                             o_bad_ch
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int WD_W = $clog2(TIMEOUT+1);
    // One extra bit so channel ids that do not fit NUM_CH can be compared.
    localparam logic [CH_W:0]   NUM_CH_L  = NUM_CH[CH_W:0];
    localparam logic [WD_W-1:0] TIMEOUT_L = TIMEOUT[WD_W-1:0];

    logic              ch_ok, push, pop;
    logic              full, empty;
    logic [CH_W-1:0]   head_ch;
    logic              head_vld;
    logic [DATA_W-1:0] head_data;

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic              bad_q, bad_d;

    assign ch_ok         = ({1'b0, i_issue_ch} < NUM_CH_L);
    assign push          = i_issue_valid && !full && ch_ok;
    assign o_issue_ready = !full;

    gc_order_fifo #(
        .WIDTH (CH_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (i_issue_ch),
        .dout_o  (head_ch),
        .full_o  (full),
        .empty_o (empty),
        .count_o (o_outstanding)
    );

    // Head mux: only the channel at the head of the order FIFO may be popped;
    // data arriving early on other channels stays in its backend FIFO.
    always_comb begin
        head_vld  = 1'b0;
        head_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (head_ch == CH_W'(c)) begin
                head_vld  = i_ret_valid[c];
                head_data = i_ret_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // The head is read from registered FIFO state, so a read pushed this cycle
    // cannot be popped before the next one.
    assign pop = !empty && head_vld;

    always_comb begin
        o_ret_ren = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_ret_ren[c] = pop && (head_ch == CH_W'(c));
        end
    end

    always_comb begin
        rvalid_d  = pop;
        rdata_d   = pop ? head_data : rdata_q;
        wd_d      = wd_q;
        timeout_d = timeout_q || (wd_q == TIMEOUT_L);
        bad_d     = bad_q || (i_issue_valid && !ch_ok);
        // Saturate so a very long wait cannot wrap the counter back to zero.
        if (empty || pop)           wd_d = '0;
        else if (wd_q != TIMEOUT_L) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            bad_q     <= bad_d;
        end
    end

    assign o_read_data_valid = rvalid_q;
    assign o_read_data       = rdata_q;
    assign o_timeout         = timeout_q;
    assign o_bad_ch          = bad_q;

endmodule

// File: tb/tb_gc_read_return_sequencer.sv
module tb_gc_read_return_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic [1:0]   issue_ch;
    logic         issue_ready;
    logic [3:0]   ret_valid;
    logic [511:0] ret_data;
    logic [3:0]   ren;
    logic         rdv;
    logic [127:0] rdata;
    logic [4:0]   outst;
    logic         tmo, bad;

    // Second instance with a 5-channel configuration for the bad-channel case.
    logic         b_issue_valid;
    logic [2:0]   b_ch;
    logic         b_ready;
    logic [4:0]   b_ret_valid;
    logic [39:0]  b_ret_data;
    logic [4:0]   b_ren;
    logic         b_rdv;
    logic [7:0]   b_rdata;
    logic [4:0]   b_outst;
    logic         b_tmo, b_bad;

    int tests = 0;
    int fails = 0;

    logic [127:0] bq [4][$];
    logic [3:0]   ren_log [$];
    logic [127:0] out_log [$];

    always #5 clk = ~clk;

    gc_read_return_sequencer #(
        .NUM_CH(4), .DATA_W(128), .ORDER_DEPTH(16), .TIMEOUT(1023)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(issue_valid), .i_issue_ch(issue_ch),
        .o_issue_ready(issue_ready), .i_ret_valid(ret_valid), .i_ret_data(ret_data),
        .o_ret_ren(ren), .o_read_data_valid(rdv), .o_read_data(rdata),
        .o_outstanding(outst), .o_timeout(tmo), .o_bad_ch(bad)
    );

    gc_read_return_sequencer #(
        .NUM_CH(5), .DATA_W(8), .ORDER_DEPTH(16), .TIMEOUT(1023)
    ) dut5 (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(b_issue_valid), .i_issue_ch(b_ch),
        .o_issue_ready(b_ready), .i_ret_valid(b_ret_valid), .i_ret_data(b_ret_data),
        .o_ret_ren(b_ren), .o_read_data_valid(b_rdv), .o_read_data(b_rdata),
        .o_outstanding(b_outst), .o_timeout(b_tmo), .o_bad_ch(b_bad)
    );

    function automatic logic [127:0] dw(input int c, input int n);
        return {32'hC0DE0000 + 32'(c), 64'h0, 32'(n)};
    endfunction

    // Backend model: each channel presents the front of its queue (FWFT).
    task automatic drive_ret();
        for (int c = 0; c < 4; c++) begin
            ret_valid[c] = (bq[c].size() != 0);
            ret_data[c*128 +: 128] = (bq[c].size() != 0) ? bq[c][0] : 128'h0;
        end
    endtask

    // One cycle: settle inputs, log ren, clock edge, pop backends, log output.
    task automatic tick();
        logic [3:0] r;
        drive_ret();
        #1;
        r = ren;
        ren_log.push_back(r);
        @(posedge clk);
        for (int c = 0; c < 4; c++)
            if (r[c] && bq[c].size() != 0) void'(bq[c].pop_front());
        #1;
        if (rdv) out_log.push_back(rdata);
    endtask

    task automatic issue(input logic [1:0] ch);
        issue_valid = 1'b1;
        issue_ch    = ch;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
        tests++; if (outst !== 5'd0) begin fails++; $display("FAIL reset_outst got %0d exp 0", outst); end
        tests++; if (rdv !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rdv); end
        tests++; if (rdata !== 128'h0) begin fails++; $display("FAIL reset_data got %h exp 0", rdata); end
        tests++; if ({tmo, bad} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {tmo, bad}); end
        tests++; if (ren !== 4'b0000) begin fails++; $display("FAIL reset_ren got %b exp 0000", ren); end
        tests++; if ({b_outst, b_bad} !== 6'd0) begin fails++; $display("FAIL reset_dut5 got %h exp 0", {b_outst, b_bad}); end
    endtask

    task automatic test_in_order();
        logic [3:0] exp_ren [4];
        int         ord [4];
        int         nz;
        exp_ren = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
        ord     = '{2, 0, 3, 1};
        for (int i = 0; i < 4; i++) issue(2'(ord[i]));
        tests++; if (outst !== 5'd4) begin fails++; $display("FAIL order_outst4 got %0d exp 4", outst); end
        ren_log.delete();
        repeat (5) tick();
        nz = 0;
        foreach (ren_log[i]) if (ren_log[i] != 4'b0) nz++;
        tests++; if (nz !== 0) begin fails++; $display("FAIL order_idle_ren got %0d strobes exp 0", nz); end
        for (int c = 0; c < 4; c++) bq[c].push_back(dw(c, 1));
        ren_log.delete();
        out_log.delete();
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            tests++; if (ren_log[i] !== exp_ren[i]) begin fails++; $display("FAIL order_ren%0d got %b exp %b", i, ren_log[i], exp_ren[i]); end
        end
        tests++; if (out_log.size() !== 4) begin fails++; $display("FAIL order_count got %0d exp 4", out_log.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (((i < out_log.size()) ? out_log[i] : 128'bx) !== dw(ord[i], 1)) begin
                fails++; $display("FAIL order_data%0d exp %h", i, dw(ord[i], 1)); end
        end
        tests++; if (outst !== 5'd0) begin fails++; $display("FAIL order_outst0 got %0d exp 0", outst); end
        tests++; if ({rdv, rdata} !== {1'b0, dw(1, 1)}) begin fails++; $display("FAIL order_hold got %b %h exp 0 %h", rdv, rdata, dw(1, 1)); end
    endtask

    task automatic test_head_blocking();
        int nz;
        issue(2'd0);
        issue(2'd1);
        bq[1].push_back(dw(1, 2));
        ren_log.delete();
        repeat (10) tick();
        nz = 0;
        foreach (ren_log[i]) if (ren_log[i] != 4'b0) nz++;
        tests++; if (nz !== 0) begin fails++; $display("FAIL block_early_ren got %0d strobes exp 0", nz); end
        tests++; if (outst !== 5'd2) begin fails++; $display("FAIL block_outst got %0d exp 2", outst); end
        bq[0].push_back(dw(0, 2));
        ren_log.delete();
        out_log.delete();
        repeat (4) tick();
        tests++; if ({ren_log[0], ren_log[1]} !== 8'b0001_0010) begin
            fails++; $display("FAIL block_ren got %b %b exp 0001 0010", ren_log[0], ren_log[1]); end
        tests++; if (out_log.size() !== 2) begin fails++; $display("FAIL block_count got %0d exp 2", out_log.size()); end
        else begin
            tests++; if ({out_log[0], out_log[1]} !== {dw(0, 2), dw(1, 2)}) begin
                fails++; $display("FAIL block_data got %h %h exp %h %h", out_log[0], out_log[1], dw(0, 2), dw(1, 2)); end
        end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 16; i++) issue(2'd3);
        tests++; if (outst !== 5'd16) begin fails++; $display("FAIL full_outst got %0d exp 16", outst); end
        tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", issue_ready); end
        for (int n = 0; n < 16; n++) bq[3].push_back(dw(3, 100 + n));
        out_log.delete();
        issue(2'd3);   // rejected while full, although a pop happens this cycle
        tests++; if (outst !== 5'd15) begin fails++; $display("FAIL full_reject got %0d exp 15", outst); end
        repeat (20) tick();
        tests++; if (outst !== 5'd0) begin fails++; $display("FAIL wrap_outst got %0d exp 0", outst); end
        tests++; if (out_log.size() !== 16) begin fails++; $display("FAIL wrap_count got %0d exp 16", out_log.size()); end
        for (int n = 0; n < 16; n++) begin
            tests++; if (((n < out_log.size()) ? out_log[n] : 128'bx) !== dw(3, 100 + n)) begin
                fails++; $display("FAIL wrap_data%0d exp %h", n, dw(3, 100 + n)); end
        end
    endtask

    task automatic test_timeout();
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL tmo_pre got %b exp 0", tmo); end
        issue(2'd1);
        repeat (1000) tick();
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL tmo_early got %b exp 0", tmo); end
        repeat (40) tick();
        tests++; if (tmo !== 1'b1) begin fails++; $display("FAIL tmo_set got %b exp 1", tmo); end
        tests++; if (outst !== 5'd1) begin fails++; $display("FAIL tmo_outst got %0d exp 1", outst); end
        bq[1].push_back(dw(1, 7));
        out_log.delete();
        repeat (2) tick();
        tests++; if ((out_log.size() == 1 ? out_log[0] : 128'bx) !== dw(1, 7)) begin
            fails++; $display("FAIL tmo_data got %0d words exp 1 of %h", out_log.size(), dw(1, 7)); end
        tests++; if ({tmo, outst} !== {1'b1, 5'd0}) begin fails++; $display("FAIL tmo_sticky got %b %0d exp 1 0", tmo, outst); end
    endtask

    task automatic test_bad_ch();
        b_issue_valid = 1'b1;
        b_ch = 3'd5;
        tick();
        tests++; if ({b_bad, b_outst} !== {1'b1, 5'd0}) begin fails++; $display("FAIL bad_set got %b %0d exp 1 0", b_bad, b_outst); end
        b_ch = 3'd4;
        tick();
        b_issue_valid = 1'b0;
        tests++; if ({b_bad, b_outst} !== {1'b1, 5'd1}) begin fails++; $display("FAIL bad_ch4 got %b %0d exp 1 1", b_bad, b_outst); end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL bad_main got %b exp 0", bad); end
    endtask

    task automatic test_reset_mid();
        issue(2'd0);
        issue(2'd1);
        issue(2'd2);
        tests++; if (outst !== 5'd3) begin fails++; $display("FAIL rst_pre got %0d exp 3", outst); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({outst, rdv, tmo, bad} !== 8'd0) begin fails++; $display("FAIL rst_state got %0d %b %b %b exp 0 0 0 0", outst, rdv, tmo, bad); end
        tests++; if ({b_outst, b_bad} !== 6'd0) begin fails++; $display("FAIL rst_dut5 got %0d %b exp 0 0", b_outst, b_bad); end
        tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", issue_ready); end
        bq[0].push_back(dw(0, 9));
        drive_ret();
        #1;
        tests++; if (ren !== 4'b0000) begin fails++; $display("FAIL rst_ren got %b exp 0000", ren); end
        bq[0].delete();
        drive_ret();
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_ch = 2'd0;
        ret_valid = '0;
        ret_data = '0;
        b_issue_valid = 1'b0;
        b_ch = 3'd0;
        b_ret_valid = '0;
        b_ret_data = '0;
        test_reset();
        test_in_order();
        test_head_blocking();
        test_full_wrap();
        test_timeout();
        test_bad_ch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
